idu_regfile16: RTL and testbench

- 16-bit register file plus Increment/Decrement Unit (IDU) for the SM83 CPU core.
- Consumes the Read16/Write16/Increment16 control vectors that the per-instruction microcode modules (INC/DEC rr, LD, PUSH/POP, fetch) drive through the control unit.
- Selects one 16-bit pair onto the address bus, applies +1, -1 or pass-through, and writes the result back on the same clock edge.
- Also gives the datapath direct 16-bit and 8-bit (W/Z) load ports.

---
 rtl/idu_regfile16.sv | 94 +++++++++
 tb/tb_idu_regfile16.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/idu_regfile16.sv
// SM83 16-bit register file (PC, BC, DE, HL, SP, WZ) with the increment/decrement unit.
// One pair is read onto the address bus, adjusted by +1/-1/0 and optionally written back in the same cycle.
module idu_regfile16 #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] SP_RESET = 16'hFFFE
) (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  input  logic [5:0]  i_Read16,
  input  logic [5:0]  i_Write16,
  input  logic [1:0]  i_Increment16,
  input  logic [5:0]  i_Load16,
  input  logic [15:0] i_Data16,
  input  logic        i_Load_W,
  input  logic        i_Load_Z,
  input  logic [7:0]  i_Data8,
  output logic [15:0] o_Addr,
  output logic [15:0] o_IDU_Out,
  output logic [15:0] o_BC,
  output logic [15:0] o_DE,
  output logic [15:0] o_HL,
  output logic [15:0] o_SP,
  output logic [15:0] o_PC,
  output logic [15:0] o_WZ,
  output logic        o_Sel_Error
);

  // Index map shared by every select vector: 0=PC 1=BC 2=DE 3=HL 4=SP 5=WZ
  logic [5:0][15:0] w_regs;
  logic [15:0]      w_addr;
  logic [15:0]      w_idu;
  logic             w_sel_err;
  logic             r_sel_error;

  // Multi-hot reads simply OR together; the error flag reports it separately
  always_comb begin
    w_addr = '0;
    for (int i = 0; i < 6; i++) begin
      if (i_Read16[i]) w_addr = w_addr | w_regs[i];
    end
  end

  always_comb begin
    case (i_Increment16)
      2'b01:   w_idu = w_addr + 16'd1;
      2'b11:   w_idu = w_addr - 16'd1;
      default: w_idu = w_addr;
    endcase
  end

  assign w_sel_err = (|(i_Read16 & (i_Read16 - 6'd1)))
                   | (|(i_Load16 & (i_Load16 - 6'd1)))
                   | (i_Increment16 == 2'b10);

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_reg
      localparam logic [15:0] RST_VAL = (gi == 0) ? PC_RESET :
                                        (gi == 4) ? SP_RESET : 16'h0000;
      localparam bit IS_WZ = (gi == 5);
      logic [15:0] r_q;

      always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
          r_q <= RST_VAL;
        end else if (i_Load16[gi]) begin
          r_q <= i_Data16;
        end else if (i_Write16[gi]) begin
          r_q <= w_idu;
        end else if (IS_WZ && (i_Load_W || i_Load_Z)) begin
          r_q <= {i_Load_W ? i_Data8 : r_q[15:8], i_Load_Z ? i_Data8 : r_q[7:0]};
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) r_sel_error <= 1'b0;
    else            r_sel_error <= w_sel_err;
  end

  assign o_Addr      = w_addr;
  assign o_IDU_Out   = w_idu;
  assign o_PC        = w_regs[0];
  assign o_BC        = w_regs[1];
  assign o_DE        = w_regs[2];
  assign o_HL        = w_regs[3];
  assign o_SP        = w_regs[4];
  assign o_WZ        = w_regs[5];
  assign o_Sel_Error = r_sel_error;

endmodule

// File: tb/tb_idu_regfile16.sv
// Directed-vector bench for idu_regfile16; expected values are hand-computed constants.
module tb_idu_regfile16;

  logic        i_Clk = 1'b0;
  logic        i_Reset_n;
  logic [5:0]  i_Read16, i_Write16, i_Load16;
  logic [1:0]  i_Increment16;
  logic [15:0] i_Data16;
  logic        i_Load_W, i_Load_Z;
  logic [7:0]  i_Data8;
  logic [15:0] o_Addr, o_IDU_Out, o_BC, o_DE, o_HL, o_SP, o_PC, o_WZ;
  logic        o_Sel_Error;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] S_PC = 6'b000001;
  localparam logic [5:0] S_BC = 6'b000010;
  localparam logic [5:0] S_DE = 6'b000100;
  localparam logic [5:0] S_HL = 6'b001000;
  localparam logic [5:0] S_SP = 6'b010000;
  localparam logic [5:0] S_WZ = 6'b100000;

  idu_regfile16 dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
    .i_Read16(i_Read16), .i_Write16(i_Write16), .i_Increment16(i_Increment16),
    .i_Load16(i_Load16), .i_Data16(i_Data16),
    .i_Load_W(i_Load_W), .i_Load_Z(i_Load_Z), .i_Data8(i_Data8),
    .o_Addr(o_Addr), .o_IDU_Out(o_IDU_Out),
    .o_BC(o_BC), .o_DE(o_DE), .o_HL(o_HL), .o_SP(o_SP), .o_PC(o_PC), .o_WZ(o_WZ),
    .o_Sel_Error(o_Sel_Error)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic idle();
    i_Read16 = '0; i_Write16 = '0; i_Load16 = '0; i_Increment16 = 2'b00;
    i_Data16 = '0; i_Load_W = 1'b0; i_Load_Z = 1'b0; i_Data8 = '0;
  endtask

  // Advance one edge and sample 1 time unit after it
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic load(input logic [5:0] sel, input logic [15:0] val);
    idle();
    i_Load16 = sel; i_Data16 = val;
    step();
    idle();
  endtask

  task automatic idu_op(input logic [5:0] sel, input logic [1:0] inc);
    idle();
    i_Read16 = sel; i_Write16 = sel; i_Increment16 = inc;
  endtask

  initial begin
    idle();
    i_Reset_n = 1'b0;
    #12;
    i_Reset_n = 1'b1;
    step();

    // Dirty every register, then reset asynchronously with a write pending
    load(S_BC, 16'h1111); load(S_DE, 16'h2222); load(S_HL, 16'h3333);
    load(S_SP, 16'h4444); load(S_PC, 16'h5555); load(S_WZ, 16'h6666);
    idu_op(S_PC, 2'b01);
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk("rst_pc", o_PC, 16'h0000);
    chk("rst_sp", o_SP, 16'hFFFE);
    chk("rst_bc", o_BC, 16'h0000);
    chk("rst_de", o_DE, 16'h0000);
    chk("rst_hl", o_HL, 16'h0000);
    chk("rst_wz", o_WZ, 16'h0000);
    chk("rst_err", {15'b0, o_Sel_Error}, 16'h0000);
    step();
    chk("rst_hold_pc", o_PC, 16'h0000);
    idle();
    #2;
    i_Reset_n = 1'b1;
    step();
    chk("idle_addr", o_Addr, 16'h0000);
    chk("idle_pc", o_PC, 16'h0000);

    // INC BC
    load(S_BC, 16'h12FF);
    idu_op(S_BC, 2'b01);
    #1;
    chk("incbc_addr", o_Addr, 16'h12FF);
    chk("incbc_idu", o_IDU_Out, 16'h1300);
    step();
    idle();
    chk("incbc_bc", o_BC, 16'h1300);
    chk("incbc_pc", o_PC, 16'h0000);
    chk("incbc_sp", o_SP, 16'hFFFE);
    chk("incbc_de", o_DE, 16'h0000);

    // DEC SP and INC HL wrap
    load(S_SP, 16'h0000);
    idu_op(S_SP, 2'b11);
    #1;
    chk("decsp_idu", o_IDU_Out, 16'hFFFF);
    step();
    idle();
    chk("decsp_sp", o_SP, 16'hFFFF);
    load(S_HL, 16'hFFFF);
    idu_op(S_HL, 2'b01);
    step();
    idle();
    chk("inchl_hl", o_HL, 16'h0000);

    // Fetch: PC++ three times
    load(S_PC, 16'h0150);
    for (int k = 0; k < 3; k++) begin
      idu_op(S_PC, 2'b01);
      #1;
      chk($sformatf("fetch_addr%0d", k), o_Addr, 16'h0150 + 16'(k));
      step();
    end
    idle();
    chk("fetch_pc", o_PC, 16'h0153);

    // Priority on WZ
    load(S_WZ, 16'h00AA);
    idu_op(S_WZ, 2'b01);
    i_Load16 = S_WZ; i_Data16 = 16'hBEEF; i_Load_Z = 1'b1; i_Data8 = 8'h55;
    step();
    idle();
    chk("prio_load16", o_WZ, 16'hBEEF);
    load(S_WZ, 16'h00AA);
    idu_op(S_WZ, 2'b01);
    i_Load_Z = 1'b1; i_Data8 = 8'h55;
    step();
    idle();
    chk("prio_write16", o_WZ, 16'h00AB);
    i_Load_W = 1'b1; i_Data8 = 8'hC3;
    step();
    idle();
    chk("load_w", o_WZ, 16'hC3AB);
    i_Load_Z = 1'b1; i_Data8 = 8'h3C;
    step();
    idle();
    chk("load_z", o_WZ, 16'hC33C);
    i_Load_W = 1'b1; i_Load_Z = 1'b1; i_Data8 = 8'h5A;
    step();
    idle();
    chk("load_wz", o_WZ, 16'h5A5A);
    chk("legal_err", {15'b0, o_Sel_Error}, 16'h0000);

    // Multi-hot read flags an error for exactly one cycle
    load(S_BC, 16'h00F0);
    load(S_DE, 16'h0F00);
    i_Read16 = S_BC | S_DE;
    #1;
    chk("multi_addr", o_Addr, 16'h0FF0);
    chk("multi_err_pre", {15'b0, o_Sel_Error}, 16'h0000);
    step();
    idle();
    chk("multi_err", {15'b0, o_Sel_Error}, 16'h0001);
    step();
    chk("multi_err_clr", {15'b0, o_Sel_Error}, 16'h0000);

    // Increment16=10 acts as pass-through but flags an error
    idu_op(S_PC, 2'b10);
    #1;
    chk("inc10_idu", o_IDU_Out, 16'h0153);
    step();
    idle();
    chk("inc10_pc", o_PC, 16'h0153);
    chk("inc10_err", {15'b0, o_Sel_Error}, 16'h0001);
    step();
    chk("inc10_err_clr", {15'b0, o_Sel_Error}, 16'h0000);

    // Multi-hot write is legal copy-to-several
    i_Read16 = S_HL; i_Write16 = S_BC | S_DE; i_Increment16 = 2'b01;
    step();
    idle();
    chk("copy_bc", o_BC, 16'h0001);
    chk("copy_de", o_DE, 16'h0001);
    chk("copy_err", {15'b0, o_Sel_Error}, 16'h0000);

    // Multi-hot direct load loads both and flags an error
    i_Load16 = S_SP | S_HL; i_Data16 = 16'h1234;
    step();
    idle();
    chk("ml_sp", o_SP, 16'h1234);
    chk("ml_hl", o_HL, 16'h1234);
    chk("ml_err", {15'b0, o_Sel_Error}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
